// File: rtl/gfx_mat_vec_arbiter.sv
// rtl/gfx_mat_vec_arbiter.sv - round-robin arbiter sharing one mat4 x vec4 multiplier among PORTS requesters
//
// Requests are granted round-robin and issued to the multiplier. Each issued
// grant index is pushed into a tag FIFO. Results are steered back to the
// issuing port in the multiplier's in-order completion order. Both the request
// and response paths are purely combinational.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_a/req_x/req_valid         per-port operands and request valid
//   req_ready                     per-port request accepted this cycle
//   resp_q/resp_valid/resp_ready  shared result data, per-port valid/ready
//   mul_a/mul_x/mul_in_valid      operands and valid to the multiplier
//   mul_in_ready                  multiplier input ready
//   mul_q/mul_out_valid           result data and valid from the multiplier
//   mul_out_ready                 result accepted by the owning port
//   busy                          one or more transactions outstanding
//   err                           sticky: result arrived with no tag outstanding
module gfx_mat_vec_arbiter #(
    parameter int PORTS  = 2,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [PORTS-1:0][16*DATA_W-1:0] req_a,
    input  logic [PORTS-1:0][4*DATA_W-1:0]  req_x,
    input  logic [PORTS-1:0]               req_valid,
    output logic [PORTS-1:0]               req_ready,
    output logic [4*DATA_W-1:0]            resp_q,
    output logic [PORTS-1:0]               resp_valid,
    input  logic [PORTS-1:0]               resp_ready,
    output logic [16*DATA_W-1:0]           mul_a,
    output logic [4*DATA_W-1:0]            mul_x,
    output logic                           mul_in_valid,
    input  logic                           mul_in_ready,
    input  logic [4*DATA_W-1:0]            mul_q,
    input  logic                           mul_out_valid,
    output logic                           mul_out_ready,
    output logic                           busy,
    output logic                           err
);

    localparam int TAG_W = $clog2(PORTS);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [TAG_W-1:0] LAST = TAG_W'(PORTS - 1);

    logic [TAG_W-1:0] prio;
    logic             locked;
    logic [TAG_W-1:0] lock_id;
    logic [TAG_W-1:0] scan_grant;
    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] next_prio;
    logic             issue;
    logic             pop;

    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [TAG_W-1:0] head;
    logic             fifo_empty;

    // Rotating priority scan: first valid port at or above prio wins. With no
    // valid port the grant rests on prio so the operand mux is well defined.
    always_comb begin
        scan_grant = prio;
        for (int k = PORTS - 1; k >= 0; k--) begin
            if (req_valid[(int'(prio) + k) % PORTS]) begin
                scan_grant = TAG_W'((int'(prio) + k) % PORTS);
            end
        end
    end

    // A stalled offer is pinned to the port that was offered so the multiplier
    // sees stable operands until it accepts them.
    assign grant      = locked ? lock_id : scan_grant;
    assign next_prio  = (grant == LAST) ? '0 : grant + 1'b1;

    assign mul_a        = req_a[grant];
    assign mul_x        = req_x[grant];
    // Full blocks issue even if a pop happens this cycle; the freed slot is
    // usable on the following cycle.
    assign mul_in_valid = (locked || (|req_valid)) && (count != FULL);
    assign issue        = mul_in_valid && mul_in_ready;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign fifo_empty    = (count == '0);
    assign head          = tag_mem[rd_ptr];
    assign resp_q        = mul_q;
    assign mul_out_ready = !fifo_empty && resp_ready[head];
    assign pop           = mul_out_valid && mul_out_ready;
    assign busy          = !fifo_empty;

    always_comb begin
        resp_valid = '0;
        if (mul_out_valid && !fifo_empty) begin
            resp_valid[head] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            tag_mem[wr_ptr] <= grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio    <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (mul_in_valid && !mul_in_ready) begin
                locked  <= 1'b1;
                lock_id <= grant;
            end else if (issue) begin
                locked  <= 1'b0;
            end

            if (issue) begin
                wr_ptr <= wr_ptr + 1'b1;
                prio   <= next_prio;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({issue, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (mul_out_valid && fifo_empty) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gfx_mat_vec_arbiter.sv
// tb/tb_gfx_mat_vec_arbiter.sv - directed self-checking bench for gfx_mat_vec_arbiter
module tb_gfx_mat_vec_arbiter;

    localparam int PORTS  = 2;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 16;

    logic                           clk = 1'b0;
    logic                           rst;
    logic [PORTS-1:0][16*DATA_W-1:0] req_a;
    logic [PORTS-1:0][4*DATA_W-1:0]  req_x;
    logic [PORTS-1:0]               req_valid;
    logic [PORTS-1:0]               req_ready;
    logic [4*DATA_W-1:0]            resp_q;
    logic [PORTS-1:0]               resp_valid;
    logic [PORTS-1:0]               resp_ready;
    logic [16*DATA_W-1:0]           mul_a;
    logic [4*DATA_W-1:0]            mul_x;
    logic                           mul_in_valid;
    logic                           mul_in_ready;
    logic [4*DATA_W-1:0]            mul_q;
    logic                           mul_out_valid;
    logic                           mul_out_ready;
    logic                           busy;
    logic                           err;

    int checks   = 0;
    int failures = 0;

    logic [16*DATA_W-1:0] m_id, m0, m1;
    logic [4*DATA_W-1:0]  x0, x1;
    logic [4*DATA_W-1:0]  p0, p1;

    always #5 clk = ~clk;

    gfx_mat_vec_arbiter #(.PORTS(PORTS), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_a        (req_a),
        .req_x        (req_x),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .resp_q       (resp_q),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .mul_a        (mul_a),
        .mul_x        (mul_x),
        .mul_in_valid (mul_in_valid),
        .mul_in_ready (mul_in_ready),
        .mul_q        (mul_q),
        .mul_out_valid(mul_out_valid),
        .mul_out_ready(mul_out_ready),
        .busy         (busy),
        .err          (err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [4*DATA_W-1:0] matvec(input logic [16*DATA_W-1:0] a,
                                                   input logic [4*DATA_W-1:0] x);
        logic [4*DATA_W-1:0] q;
        logic [DATA_W-1:0]   acc;
        for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int c = 0; c < 4; c++) begin
                acc = acc + DATA_W'(a[(r*4+c)*DATA_W +: DATA_W] * x[c*DATA_W +: DATA_W]);
            end
            q[r*DATA_W +: DATA_W] = acc;
        end
        return q;
    endfunction

    task automatic idle_inputs();
        req_valid     = '0;
        resp_ready    = '0;
        mul_in_ready  = 1'b0;
        mul_out_valid = 1'b0;
        mul_q         = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m_id[(r*4+c)*DATA_W +: DATA_W] = (r == c) ? 16'd1 : 16'd0;
                m0[(r*4+c)*DATA_W +: DATA_W]   = DATA_W'(r*4 + c + 1);
                m1[(r*4+c)*DATA_W +: DATA_W]   = DATA_W'(2*(r + c) + 1);
            end
            x0[r*DATA_W +: DATA_W] = DATA_W'(r + 1);
            x1[r*DATA_W +: DATA_W] = DATA_W'(r + 5);
        end
        p0 = matvec(m0, x0);
        p1 = matvec(m1, x1);

        // Reset state
        idle_inputs();
        req_a = '0;
        req_x = '0;
        rst   = 1'b1;
        step();
        step();
        rst = 1'b0;
        settle();
        check("rst_busy", busy, 0);
        check("rst_in_valid", mul_in_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_out_ready", mul_out_ready, 0);
        check("rst_err", err, 0);

        // Single port 0, identity matrix
        req_a[0] = m_id;
        req_x[0] = x0;
        req_valid = 2'b01;
        mul_in_ready = 1'b1;
        settle();
        check("t1_in_valid", mul_in_valid, 1);
        check("t1_req_ready", req_ready, 2'b01);
        check("t1_mul_a", mul_a, m_id);
        check("t1_mul_x", mul_x, x0);
        step();
        req_valid = '0;
        settle();
        check("t1_busy", busy, 1);
        mul_out_valid = 1'b1;
        mul_q = x0;
        resp_ready = 2'b01;
        settle();
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_q", resp_q, x0);
        check("t1_out_ready", mul_out_ready, 1);
        step();
        mul_out_valid = 1'b0;
        settle();
        check("t1_busy_after", busy, 0);

        // Both ports valid, full-rate issue alternates 0,1,0,1
        do_reset();
        req_a[0] = m0; req_x[0] = x0;
        req_a[1] = m1; req_x[1] = x1;
        req_valid = 2'b11;
        mul_in_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("t2_mul_a", mul_a, (k % 2 == 0) ? m0 : m1);
            step();
        end
        req_valid = '0;
        resp_ready = 2'b11;
        mul_out_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mul_q = (k % 2 == 0) ? p0 : p1;
            settle();
            check("t2_resp_valid", resp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("t2_resp_q", resp_q, (k % 2 == 0) ? p0 : p1);
            step();
        end
        mul_out_valid = 1'b0;
        settle();
        check("t2_busy", busy, 0);

        // Stall locks the grant on port 1
        do_reset();
        req_valid = 2'b10;
        mul_in_ready = 1'b0;
        settle();
        check("t3_in_valid", mul_in_valid, 1);
        check("t3_mul_a0", mul_a, m1);
        step();
        req_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            settle();
            check("t3_stall_ready", req_ready, 0);
            check("t3_stall_mul_a", mul_a, m1);
            step();
        end
        mul_in_ready = 1'b1;
        settle();
        check("t3_issue1", req_ready, 2'b10);
        check("t3_issue1_a", mul_a, m1);
        step();
        req_valid = 2'b01;
        settle();
        check("t3_issue0", req_ready, 2'b01);
        step();

        // Full FIFO: 8 issues then stall; pop frees a slot one cycle later
        do_reset();
        req_valid = 2'b01;
        mul_in_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            settle();
            check("t4_fill", mul_in_valid, 1);
            step();
        end
        settle();
        check("t4_full", mul_in_valid, 0);
        check("t4_full_busy", busy, 1);
        mul_out_valid = 1'b1;
        resp_ready = 2'b01;
        settle();
        check("t4_pop_ready", mul_out_ready, 1);
        check("t4_pop_same_cycle", mul_in_valid, 0);
        step();
        mul_out_valid = 1'b0;
        settle();
        check("t4_ninth", req_ready, 2'b01);
        step();
        settle();
        check("t4_full_again", mul_in_valid, 0);

        // Protocol error on empty FIFO
        do_reset();
        mul_out_valid = 1'b1;
        resp_ready = 2'b11;
        settle();
        check("t5_resp_valid", resp_valid, 0);
        check("t5_out_ready", mul_out_ready, 0);
        check("t5_err_now", err, 0);
        step();
        mul_out_valid = 1'b0;
        settle();
        check("t5_err_set", err, 1);
        step();
        check("t5_err_held", err, 1);
        do_reset();
        settle();
        check("t5_err_clr", err, 0);

        // Reset with 3 outstanding, prio left at 1
        req_valid = 2'b10;
        mul_in_ready = 1'b1;
        step();
        step();
        req_valid = 2'b01;
        step();
        req_valid = 2'b11;
        settle();
        check("t6_busy_pre", busy, 1);
        check("t6_grant_pre", req_ready, 2'b10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        check("t6_busy", busy, 0);
        check("t6_grant", req_ready, 2'b01);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gfx_mat_vec_arbiter.md
# gfx_mat_vec_arbiter

Round-robin arbiter sharing one `gfx_mat_vec` multiplier among `PORTS` requesters (vertex transform, matrix-matrix sequencer, lighting). Each request is one mat4 × vec4 transaction. A grant-tag FIFO returns every result to its issuing requester, in the multiplier's in-order completion order. The block sits between the requesters and the multiplier's in/out handshakes; it adds no data latency.

## Interface
- `PORTS`, 2: number of requesters, at least 2.
- `DEPTH`, 8: maximum transactions outstanding inside the multiplier; a power of 2, at least 2.

- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_a[PORTS]`  in  mat4  per-requester matrix.
- `req_x[PORTS]`  in  vec4  per-requester vector.
- `req_valid[PORTS]`  in  1  request valid.
- `req_ready[PORTS]`  out  1  request accepted this cycle.
- `resp_q`  out  vec4  result; shared by all ports, equals `mul_q`.
- `resp_valid[PORTS]`  out  1  result valid for port i.
- `resp_ready[PORTS]`  in  1  port i consumes result.
- `mul_a`, `mul_x`  out  mat4/vec4  operands to the multiplier.
- `mul_in_valid`  out  1; `mul_in_ready`  in  1.
- `mul_q`  in  vec4; `mul_out_valid`  in  1; `mul_out_ready`  out  1.
- `busy`  out  1  one or more transactions outstanding.
- `err`  out  1  sticky; set when `mul_out_valid` arrives with the tag FIFO empty.

## Operation
- Grant, combinational:
  - Scan from `prio` upward, mod `PORTS`.
  - The first port with `req_valid` set wins.
  - `mul_a`/`mul_x` mux the winner's operands.
  - With no valid port, the operands mux port `prio`.
- Lock:
  - When `mul_in_valid && !mul_in_ready`, register `locked`=1 and `lock_id`=winner.
  - While locked, the grant is forced to `lock_id`, so the operands and `mul_in_valid` stay stable regardless of other ports.
  - `locked` clears on issue.
- Issue signals:
  - `mul_in_valid` = (locked or any `req_valid`) && `count` != `DEPTH`. It never depends on `mul_in_ready`.
  - `req_ready[i]` = `mul_in_valid && mul_in_ready` && grant == i.
  - Issue is `mul_in_valid && mul_in_ready`.
- On issue:
  - Push the grant index into the tag FIFO.
  - Set `prio` to (grant+1) mod `PORTS`.
- Tag FIFO:
  - `DEPTH` entries of clog2(`PORTS`) bits.
  - Read/write pointers wrap mod `DEPTH`.
  - `count` is clog2(`DEPTH`)+1 bits.
- Full rule:
  - When `count`==`DEPTH`, `mul_in_valid`=0.
  - This holds even if a pop happens the same cycle; the slot frees on the next cycle.
- Return path:
  - `resp_valid[i]` = `mul_out_valid` && `count`!=0 && head == i.
  - `mul_out_ready` = `count`!=0 && `resp_ready[head]`.
  - Pop on `mul_out_valid && mul_out_ready`.
- Simultaneous push and pop (`count` not full): `count` is unchanged; both pointers advance.
- Protocol error: `mul_out_valid` with `count`==0:
  - All `resp_valid` stay 0 and `mul_out_ready`=0.
  - `err` is set and held until `rst`.
- `busy` = `count`!=0.

## Timing
- Reset, synchronous: all of the following take effect at the first edge with `rst`=1.
  - `prio`=0, `locked`=0, pointers=0, `count`=0, `err`=0.
  - Resulting outputs: `busy`=0, `mul_in_valid`=0 unless a `req_valid` is set, all `resp_valid`=0, `mul_out_ready`=0.
- Reset mid-operation: the FIFO contents are discarded. The multiplier must be reset in the same cycle. Results it emits after reset raise `err`.
- Request path: combinational; `req_valid[i]` to `mul_in_valid` takes 0 cycles.
- Response path: combinational; `mul_out_valid` to `resp_valid` takes 0 cycles. There are no bubbles, so a full-rate multiplier sustains 1 transaction/cycle.
- Register timing:
  - `prio` updates the cycle after issue.
  - `locked` sets the cycle after a stalled offer.
- Fairness: a continuously requesting port is granted within `PORTS` issues.
- Requester obligation: keep `req_valid` and operands stable until `req_ready`.

## Test plan
- Single port 0, A=identity, x=(1,2,3,4): `req_ready[0]` in the same cycle. When the multiplier outputs (1,2,3,4), `resp_valid[0]`=1 and `resp_valid[1]`=0. `busy` drops after the pop.
- Both ports valid every cycle, `mul_in_ready`=1: grants alternate 0,1,0,1. Results return tagged 0,1,0,1, each carrying its own port's product.
- Port 1 offered with `mul_in_ready`=0 for 3 cycles, port 0 raising valid during the stall: the grant stays 1 and `mul_a` is unchanged. Port 1 issues on the first ready cycle; port 0 issues next.
- `resp_ready`=0 on all ports, `DEPTH`=8: exactly 8 issues, then `mul_in_valid`=0. A single pop in cycle N allows the 9th issue in cycle N+1, not in N.
- `mul_out_valid` pulsed with an empty FIFO: `err`=1 from the next cycle and held, with no `resp_valid`. `rst` clears it.
- Assert `rst` with 3 outstanding: the next cycle shows `count`=0, `busy`=0, `prio`=0, and the first grant goes to port 0.
